// File: rtl/led_frame_capture.sv
// Passive observer of the 16x16 LED scan bus: debounces each row dwell,
// rebuilds red/green frames in a shadow buffer and publishes complete scans.
module led_frame_capture #(
  parameter int STABLE_SAMPLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_en,
  input  logic [35:0]            gpio_in,
  input  logic                   clear_err,
  output logic [15:0][15:0]      red_frame,
  output logic [15:0][15:0]      grn_frame,
  output logic                   frame_valid,
  output logic                   frame_changed,
  output logic [CNT_W-1:0]       frame_count,
  output logic                   locked,
  output logic                   seq_err
);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [7:0] STAB_MAX = 8'(STABLE_SAMPLES);

  // Dwell tracker state
  logic [35:0]       word_reg;
  logic              word_valid_reg;
  logic [7:0]        stab_cnt_reg;
  logic [7:0]        stab_cnt_next;
  logic              word_same;
  logic              commit;

  // Frame assembly state
  state_t            state_reg;
  state_t            state_next;
  logic [3:0]        expect_reg;
  logic [3:0]        expect_next;
  logic [15:0][15:0] shadow_red_reg;
  logic [15:0][15:0] shadow_grn_reg;
  logic              shadow_wr;
  logic              shadow_clr;
  logic              publish;
  logic              err;

  // Published outputs
  logic [15:0][15:0] red_frame_reg;
  logic [15:0][15:0] grn_frame_reg;
  logic [15:0][15:0] pub_red;
  logic [15:0][15:0] pub_grn;
  logic              frame_valid_reg;
  logic              frame_changed_reg;
  logic              frame_changed_next;
  logic [CNT_W-1:0]  frame_count_reg;
  logic              locked_reg;
  logic              seq_err_reg;

  logic [3:0]        cur_row;
  logic [15:0]       cur_red;
  logic [15:0]       cur_grn;

  assign cur_row = gpio_in[35:32];
  assign cur_red = gpio_in[31:16];
  assign cur_grn = gpio_in[15:0];

  // The first sample after reset has no predecessor, so it always starts a dwell.
  assign word_same = word_valid_reg && (gpio_in == word_reg);

  always_comb begin
    stab_cnt_next = stab_cnt_reg;
    if (sample_en) begin
      if (word_same) begin
        stab_cnt_next = (stab_cnt_reg == STAB_MAX) ? STAB_MAX : stab_cnt_reg + 8'd1;
      end else begin
        stab_cnt_next = 8'd1;
      end
    end
  end

  // Commit exactly once per dwell: only on the transition into saturation.
  assign commit = sample_en
               && (stab_cnt_next == STAB_MAX)
               && (!word_same || (stab_cnt_reg != STAB_MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      stab_cnt_reg   <= '0;
    end else if (sample_en) begin
      word_reg       <= gpio_in;
      word_valid_reg <= 1'b1;
      stab_cnt_reg   <= stab_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    expect_next = expect_reg;
    shadow_wr   = 1'b0;
    shadow_clr  = 1'b0;
    publish     = 1'b0;
    err         = 1'b0;
    if (commit) begin
      case (state_reg)
        HUNT: begin
          if (cur_row == 4'd0) begin
            shadow_wr   = 1'b1;
            expect_next = 4'd1;
            state_next  = COLLECT;
          end
        end
        COLLECT: begin
          if (cur_row == expect_reg) begin
            if (cur_row == 4'd15) begin
              publish     = 1'b1;
              expect_next = 4'd0;
            end else begin
              shadow_wr   = 1'b1;
              expect_next = expect_reg + 4'd1;
            end
          end else begin
            err         = 1'b1;
            shadow_clr  = 1'b1;
            state_next  = HUNT;
            expect_next = 4'd0;
            // An out-of-order row 0 is also a fresh start of frame.
            if (cur_row == 4'd0) begin
              shadow_wr   = 1'b1;
              expect_next = 4'd1;
              state_next  = COLLECT;
            end
          end
        end
        default: begin
          state_next  = HUNT;
          expect_next = 4'd0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_row
      // Row-write wins over discard so a restarting row 0 survives the clear.
      always_ff @(posedge clk) begin
        if (!reset) begin
          shadow_red_reg[gi] <= '0;
          shadow_grn_reg[gi] <= '0;
        end else if (shadow_wr && (cur_row == 4'(gi))) begin
          shadow_red_reg[gi] <= cur_red;
          shadow_grn_reg[gi] <= cur_grn;
        end else if (shadow_clr) begin
          shadow_red_reg[gi] <= '0;
          shadow_grn_reg[gi] <= '0;
        end
      end

      if (gi == 15) begin : g_last
        assign pub_red[gi] = cur_red;
        assign pub_grn[gi] = cur_grn;
      end else begin : g_body
        assign pub_red[gi] = shadow_red_reg[gi];
        assign pub_grn[gi] = shadow_grn_reg[gi];
      end
    end
  endgenerate

  assign frame_changed_next = (pub_red != red_frame_reg) || (pub_grn != grn_frame_reg);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= HUNT;
      expect_reg        <= '0;
      red_frame_reg     <= '0;
      grn_frame_reg     <= '0;
      frame_valid_reg   <= 1'b0;
      frame_changed_reg <= 1'b0;
      frame_count_reg   <= '0;
      locked_reg        <= 1'b0;
      seq_err_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      expect_reg      <= expect_next;
      locked_reg      <= (state_next == COLLECT);
      frame_valid_reg <= publish;
      if (publish) begin
        red_frame_reg     <= pub_red;
        grn_frame_reg     <= pub_grn;
        frame_changed_reg <= frame_changed_next;
        frame_count_reg   <= frame_count_reg + 1'b1;
      end
      if (err) begin
        seq_err_reg <= 1'b1;
      end else if (clear_err) begin
        seq_err_reg <= 1'b0;
      end
    end
  end

  assign red_frame     = red_frame_reg;
  assign grn_frame     = grn_frame_reg;
  assign frame_valid   = frame_valid_reg;
  assign frame_changed = frame_changed_reg;
  assign frame_count   = frame_count_reg;
  assign locked        = locked_reg;
  assign seq_err       = seq_err_reg;

endmodule

// File: tb/tb_led_frame_capture.sv
// Scoreboard bench for led_frame_capture: stimulus pushes expected frames,
// a negedge monitor pops and compares on every frame_valid.
module tb_led_frame_capture;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_en;
  logic [35:0]       gpio_in;
  logic              clear_err;
  logic [15:0][15:0] red_frame;
  logic [15:0][15:0] grn_frame;
  logic              frame_valid;
  logic              frame_changed;
  logic [7:0]        frame_count;
  logic              locked;
  logic              seq_err;

  int tests  = 0;
  int failed = 0;
  int frames_seen = 0;
  logic fv_prev = 1'b0;

  typedef struct {
    logic [255:0] red;
    logic [255:0] grn;
    logic         changed;
    logic [7:0]   count;
  } exp_t;

  exp_t exp_q[$];

  logic [15:0] a_red [16];
  logic [15:0] a_grn [16];
  logic [15:0] b_red [16];
  logic [15:0] b_grn [16];

  led_frame_capture #(.STABLE_SAMPLES(4), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_en     (sample_en),
    .gpio_in       (gpio_in),
    .clear_err     (clear_err),
    .red_frame     (red_frame),
    .grn_frame     (grn_frame),
    .frame_valid   (frame_valid),
    .frame_changed (frame_changed),
    .frame_count   (frame_count),
    .locked        (locked),
    .seq_err       (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input bit use_b, input logic changed, input logic [7:0] count);
    exp_t e;
    logic [15:0][15:0] fr;
    logic [15:0][15:0] fg;
    for (int r = 0; r < 16; r++) begin
      fr[r] = use_b ? b_red[r] : a_red[r];
      fg[r] = use_b ? b_grn[r] : a_grn[r];
    end
    e.red = fr;
    e.grn = fg;
    e.changed = changed;
    e.count = count;
    exp_q.push_back(e);
  endtask

  task automatic drive_row(input int r, input bit use_b, input int hold, input bit toggle);
    logic [15:0] rr;
    logic [15:0] gg;
    rr = use_b ? b_red[r] : a_red[r];
    gg = use_b ? b_grn[r] : a_grn[r];
    for (int i = 0; i < hold; i++) begin
      gpio_in   = {4'(r), rr, gg};
      sample_en = toggle ? ((i % 2) == 0) : 1'b1;
      tick();
    end
  endtask

  // Drive rows first..last in order, optionally skipping one row.
  task automatic scan(input int first, input int last, input int skip_row,
                      input bit use_b, input int hold, input bit toggle);
    for (int r = first; r <= last; r++) begin
      if (r != skip_row) drive_row(r, use_b, hold, toggle);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_red"}, red_frame, '0);
    check({tag, "_grn"}, grn_frame, '0);
    check({tag, "_count"}, 256'(frame_count), '0);
    check({tag, "_valid"}, 256'(frame_valid), '0);
    check({tag, "_changed"}, 256'(frame_changed), '0);
    check({tag, "_locked"}, 256'(locked), '0);
    check({tag, "_seq_err"}, 256'(seq_err), '0);
  endtask

  // Monitor: one line per published frame.
  always @(negedge clk) begin
    if (fv_prev) check("frame_valid_width", 256'(frame_valid), '0);
    if (frame_valid && !fv_prev) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_frame_valid: got frame_count %0d, expected no frame", frame_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_red", red_frame, e.red);
        check("frame_grn", grn_frame, e.grn);
        check("frame_changed", 256'(frame_changed), 256'(e.changed));
        check("frame_count", 256'(frame_count), 256'(e.count));
        $display("[TB] frame %0d published: count=%0d changed=%0b", frames_seen, frame_count, frame_changed);
      end
    end
    fv_prev = frame_valid;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 16; r++) begin
      a_red[r] = 16'h0001 << r;
      a_grn[r] = 16'h0000;
      b_red[r] = 16'hFFFF ^ (16'h0001 << r);
      b_grn[r] = 16'h8000 >> r;
    end
    reset = 1'b0;
    sample_en = 1'b0;
    gpio_in = '0;
    clear_err = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b1;

    // Rows held 3 samples: never reach stability.
    scan(0, 15, -1, 1'b0, 3, 1'b0);
    check("short_locked", 256'(locked), '0);
    check("short_count", 256'(frame_count), '0);
    $display("[TB] short-dwell scan done");

    // Clean diagonal scan.
    push_frame(1'b0, 1'b1, 8'd1);
    scan(0, 15, -1, 1'b0, 4, 1'b0);
    tick();
    check("scan1_seq_err", 256'(seq_err), '0);
    check("scan1_locked", 256'(locked), 1);
    check("scan1_count", 256'(frame_count), 1);

    // Two identical scans.
    push_frame(1'b0, 1'b0, 8'd2);
    scan(0, 15, -1, 1'b0, 4, 1'b0);
    push_frame(1'b0, 1'b0, 8'd3);
    scan(0, 15, -1, 1'b0, 4, 1'b0);
    tick();
    check("repeat_count", 256'(frame_count), 3);

    // Skip row 6 in a pattern-B scan.
    scan(0, 15, 6, 1'b1, 4, 1'b0);
    tick();
    check("skip_seq_err", 256'(seq_err), 1);
    check("skip_locked", 256'(locked), '0);
    check("skip_count", 256'(frame_count), 3);
    check("skip_red_held", red_frame, 256'({a_red[15], a_red[14], a_red[13], a_red[12],
                                             a_red[11], a_red[10], a_red[9], a_red[8],
                                             a_red[7], a_red[6], a_red[5], a_red[4],
                                             a_red[3], a_red[2], a_red[1], a_red[0]}));
    push_frame(1'b1, 1'b1, 8'd4);
    scan(0, 15, -1, 1'b1, 4, 1'b0);
    tick();
    check("recover_seq_err_sticky", 256'(seq_err), 1);
    check("recover_count", 256'(frame_count), 4);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clear_err", 256'(seq_err), '0);
    $display("[TB] sequence-error recovery done");

    // Reset in the middle of a frame.
    scan(0, 8, -1, 1'b0, 4, 1'b0);
    reset = 1'b0;
    tick();
    check_all_zero("midreset");
    tick();
    reset = 1'b1;
    push_frame(1'b0, 1'b1, 8'd1);
    scan(0, 15, -1, 1'b0, 4, 1'b0);
    tick();
    check("post_reset_count", 256'(frame_count), 1);

    // sample_en toggling every cycle, rows held 8 clocks.
    push_frame(1'b0, 1'b0, 8'd2);
    scan(0, 15, -1, 1'b0, 8, 1'b1);
    repeat (3) tick();
    check("toggle_count", 256'(frame_count), 2);
    check("scoreboard_empty", 256'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/led_frame_capture.md
# led_frame_capture

Passive reader for the 16x16 LED-matrix scan bus that the LED driver writes on GPIO_1. It samples the row-scanned bus, debounces each row dwell, and rebuilds the full red/green pixel frames. The rebuilt frames come out as registered 16x16 arrays with a one-cycle frame strobe. It sits beside the LED driver for hardware loopback checking and gives the board testbench a frame-level observation point.

## Interface
- STABLE_SAMPLES, 4: consecutive identical enabled samples required before a row is committed (legal 1..255).
- CNT_W, 8: width of frame_count.
- clk  input  1  system clock (same clock as the scan bus source).
- reset  input  1  synchronous, active-low reset: sampled on the rising edge of clk, and the block is reset while reset==0.
- sample_en  input  1  sample qualifier; the bus is examined only on cycles where it is 1.
- gpio_in  input  36  scan bus: [35:32] row select, [31:16] red columns (bit 16 = column 0), [15:0] green columns (bit 0 = column 0); all active-high.
- clear_err  input  1  clears seq_err.
- red_frame  output  16x16  last complete red frame, indexed [row][col].
- grn_frame  output  16x16  last complete green frame, indexed [row][col].
- frame_valid  output  1  one-cycle pulse when a new frame is published.
- frame_changed  output  1  valid with frame_valid: 1 if the published frame differs from the previous published frame.
- frame_count  output  CNT_W  number of frames published; wraps modulo 2^CNT_W.
- locked  output  1  1 while in COLLECT.
- seq_err  output  1  sticky row-sequence error flag.

## Operation
- Reset values:
  - red_frame, grn_frame, frame_count, frame_valid, frame_changed, seq_err and locked are all 0.
  - FSM is in HUNT, expect is 0, the stability counter is 0, and the shadow frame is 0.
- Dwell tracking:
  - Runs only on sample_en cycles.
  - If gpio_in equals the previously sampled word, the stability counter increments and saturates at STABLE_SAMPLES.
  - Otherwise the counter loads 1 and the sampled word is stored.
- A commit event happens when the counter reaches STABLE_SAMPLES. There is at most one commit per dwell; a row held for longer never commits twice.
- The first enabled sample after reset counts as a changed word.
- A data change with the row select unchanged starts a new dwell and can commit the same row again. That recommit counts as a sequence error unless the row equals expect.
- State HUNT:
  - A commit of row 0 writes shadow row 0, sets expect=1 and moves to COLLECT.
  - Commits of rows 1..15 are ignored.
- State COLLECT, commit of row r == expect:
  - Writes shadow[r] from the column fields.
  - Sets expect = (r+1) mod 16.
- State COLLECT, commit of row 15 (publish):
  - red_frame/grn_frame load the shadow, including row 15 from the current word.
  - frame_valid=1 and frame_count increments.
  - frame_changed = (new frame != old red_frame/grn_frame).
  - The FSM stays in COLLECT with expect=0.
- State COLLECT, commit of row r != expect:
  - seq_err is set and the FSM returns to HUNT.
  - The shadow contents are discarded; published frames are untouched.
  - If r==0, this same commit is also taken as a HUNT row-0 commit: shadow row 0 is written, expect=1 and the FSM re-enters COLLECT.
- All-zero column data is a valid row; blank rows are committed normally.
- clear_err clears seq_err.
  - If an error occurs in the same cycle as clear_err, seq_err ends at 1.
- Reset asserted mid-frame discards the partial shadow and returns everything to reset values on that edge.
- sample_en=0 freezes dwell tracking and the FSM. Published outputs hold, and frame_valid is still a single-cycle pulse.

## Timing
- All outputs are registered; nothing is combinational from input to output.
- A commit takes effect on the clk edge that samples the STABLE_SAMPLES-th identical word.
- For rows held steady from their first sample, row-to-commit latency is STABLE_SAMPLES enabled samples.
- Publish:
  - red_frame, grn_frame, frame_count and frame_changed update on the row-15 commit edge.
  - frame_valid is high for exactly the following clk cycle, then 0, regardless of sample_en.
- A complete clean scan from HUNT needs at least 16×STABLE_SAMPLES enabled samples, starting at a row-0 dwell.
- seq_err sets on the offending commit edge.
- locked follows the FSM state with no extra delay.

## Test plan
- Reset, then drive rows 0..15 in order, each held 4 samples, with red[r] = 16'h0001<<r and green = 0. Expected:
  - frame_valid pulses once and frame_count=1.
  - red_frame is the identity diagonal and grn_frame=0.
  - frame_changed=1 and seq_err=0.
- Repeat the identical scan twice. Expected: two frame_valid pulses, frame_count=3, frame_changed=0 both times, frames unchanged.
- Hold each row for only 3 samples with STABLE_SAMPLES=4. Expected: no commits, locked stays 0, frame_valid never asserts.
- Inside a clean scan, skip from row 5 to row 7. Expected:
  - seq_err=1 and locked=0.
  - The published frame stays at its prior value.
  - The next clean 0..15 scan publishes and frame_count increments by 1.
  - Asserting clear_err then sets seq_err to 0.
- Drive reset low while rows 0..8 have been committed, then release and run a full scan. Expected:
  - All outputs read 0 on the reset edge.
  - The following scan publishes with frame_count=1.
- Run one scan with sample_en toggling 1/0 every cycle, each row held 8 clk cycles. Expected: identical frame published, frame_valid exactly one cycle wide.
